argo_chan_receiver: RTL and testbench

ARGO_CHAN_RECEIVER -- requirements
Module: argo_chan_receiver

---
 rtl/argo_pkg.sv | 17 +
 rtl/argo_sync_fifo.sv | 55 +++++
 rtl/argo_chan_receiver.sv | 86 ++++++++
 tb/tb_argo_chan_receiver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/argo_pkg.sv
// rtl/argo_pkg.sv - shared argo channel types and defaults
package argo_pkg;

  localparam int ARGO_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } argo_state_e;

  // Only RUN admits new words; DRAIN and DONE only empty the buffer.
  function automatic logic argo_accepting(input argo_state_e st);
    return st == ST_RUN;
  endfunction

endpackage

// File: rtl/argo_sync_fifo.sv
// rtl/argo_sync_fifo.sv - show-ahead synchronous fifo with wrapping pointers
module argo_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           count;

  // Storage is deliberately left out of reset; only pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rptr];

endmodule

// File: rtl/argo_chan_receiver.sv
// rtl/argo_chan_receiver.sv - channel receiver with flush/drain fsm, word count and xor checksum
module argo_chan_receiver
  import argo_pkg::*;
#(
  parameter int DATA_WIDTH = ARGO_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  ivalid,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic                  oready,
  output logic                  ovalid,
  output logic [DATA_WIDTH-1:0] dataout,
  input  logic                  iready,
  input  logic                  flush,
  output logic                  done,
  output logic [31:0]           word_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  argo_state_e state;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // oready depends only on registered state so upstream never sees a combinational loop.
  assign oready = argo_accepting(state) && !full;
  assign ovalid = !empty;
  assign push   = ivalid && oready;
  assign pop    = ovalid && iready;

  argo_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (datain),
    .full   (full),
    .empty  (empty),
    .rdata  (dataout)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_RUN;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      word_count <= '0;
      checksum   <= '0;
    end else if (push) begin
      word_count <= word_count + 32'd1;
      checksum   <= checksum ^ datain;
    end
  end

endmodule

// File: tb/tb_argo_chan_receiver.sv
// tb/tb_argo_chan_receiver.sv - scoreboard bench for argo_chan_receiver
module tb_argo_chan_receiver;

  logic        clock;
  logic        resetn;
  logic        ivalid;
  logic [31:0] datain;
  logic        oready;
  logic        ovalid;
  logic [31:0] dataout;
  logic        iready;
  logic        flush;
  logic        done;
  logic [31:0] word_count;
  logic [31:0] checksum;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wc;
  logic [31:0] exp_cs;

  argo_chan_receiver dut (
    .clock      (clock),
    .resetn     (resetn),
    .ivalid     (ivalid),
    .datain     (datain),
    .oready     (oready),
    .ovalid     (ovalid),
    .dataout    (dataout),
    .iready     (iready),
    .flush      (flush),
    .done       (done),
    .word_count (word_count),
    .checksum   (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: accepted words are queued, delivered words are popped and compared.
  always @(negedge clock) begin
    if (resetn) begin
      if (ivalid && oready) begin
        exp_q.push_back(datain);
      end
      if (ovalid && iready) begin
        if (exp_q.size() == 0) begin
          chk("underflow", 32'd1, 32'd0);
        end else begin
          chk("dataout", dataout, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drain_all();
    ivalid = 1'b0;
    iready = 1'b1;
    for (int k = 0; k < 20 && ovalid; k++) step();
    chk("drained", {31'd0, ovalid}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [31:0] w;
    n_cmp  = 0;
    n_err  = 0;
    exp_wc = 0;
    exp_cs = 0;
    resetn = 1'b0;
    ivalid = 1'b0;
    datain = '0;
    iready = 1'b0;
    flush  = 1'b0;

    #2;
    chk("rst_oready", {31'd0, oready}, 32'd1);
    chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wc", word_count, 32'd0);
    chk("rst_cs", checksum, 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_oready", {31'd0, oready}, 32'd1);

    // single word
    iready = 1'b1;
    ivalid = 1'b1;
    datain = 32'h19700328;
    exp_wc++; exp_cs ^= 32'h19700328;
    step();
    ivalid = 1'b0;
    chk("single_ovalid", {31'd0, ovalid}, 32'd1);
    chk("single_wc", word_count, exp_wc);
    chk("single_cs", checksum, exp_cs);
    step();
    chk("single_empty", {31'd0, ovalid}, 32'd0);

    // back-pressure: five offered, four fit
    iready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ivalid = 1'b1;
      datain = 32'hB0 + i;
      if (i < 4) begin
        exp_wc++; exp_cs ^= 32'hB0 + i;
      end
      step();
      if (i == 3) chk("bp_full_oready", {31'd0, oready}, 32'd0);
    end
    ivalid = 1'b0;
    chk("bp_wc", word_count, exp_wc);
    chk("bp_queue", exp_q.size(), 32'd4);
    iready = 1'b1;
    step();
    chk("bp_oready_back", {31'd0, oready}, 32'd1);
    drain_all();

    // streaming 25 words
    iready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      w = (i == 0) ? 32'h19700328 : (i == 1) ? 32'h19700101 : 32'(i % 7);
      ivalid = 1'b1;
      datain = w;
      exp_wc++; exp_cs ^= w;
      step();
    end
    ivalid = 1'b0;
    chk("stream_wc", word_count, exp_wc);
    chk("stream_cs", checksum, exp_cs);
    drain_all();

    // flush with 3 buffered words
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1;
      datain = 32'hF0 + i;
      exp_wc++; exp_cs ^= 32'hF0 + i;
      step();
    end
    ivalid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_oready", {31'd0, oready}, 32'd0);
    chk("flush_no_done", {31'd0, done}, 32'd0);
    iready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      step();
      if (done) seen = 1;
    end
    chk("flush_done_seen", seen, 32'd1);
    chk("flush_queue", exp_q.size(), 32'd0);
    step();
    chk("flush_done_pulse", {31'd0, done}, 32'd0);
    chk("flush_run_oready", {31'd0, oready}, 32'd1);

    // flush on empty buffer: done two cycles after the flush edge
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("eflush_d1", {31'd0, done}, 32'd0);
    chk("eflush_oready", {31'd0, oready}, 32'd0);
    step();
    chk("eflush_d2", {31'd0, done}, 32'd1);
    step();
    chk("eflush_d3", {31'd0, done}, 32'd0);
    chk("eflush_run", {31'd0, oready}, 32'd1);

    // async reset with 2 words buffered
    iready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ivalid = 1'b1;
      datain = 32'hC0 + i;
      step();
    end
    ivalid = 1'b0;
    chk("ar_ovalid_pre", {31'd0, ovalid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_ovalid", {31'd0, ovalid}, 32'd0);
    chk("ar_wc", word_count, 32'd0);
    chk("ar_cs", checksum, 32'd0);
    chk("ar_oready", {31'd0, oready}, 32'd1);
    exp_q.delete();
    exp_wc = 0;
    exp_cs = 0;
    step();
    resetn = 1'b1;
    step();

    // wrap: 10 push/pop cycles through a 4-deep buffer
    iready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ivalid = 1'b1;
      datain = 32'hA000 + i;
      exp_wc++; exp_cs ^= 32'hA000 + i;
      step();
    end
    ivalid = 1'b0;
    chk("wrap_wc", word_count, exp_wc);
    chk("wrap_cs", checksum, exp_cs);
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
